ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RISC-V core: consumes the decoded `control_signals_t` bundle plus operands, generates the immediate, selects ALU operands, computes the result and hands a writeback request downstream. A two-entry skid buffer (output register plus skid register) decouples decode from writeback under valid/ready backpressure, and a flush input discards in-flight work.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk` in 1: clock, all state updates on rising edge.
- `rst_n` in 1: reset. Synchronous and active-low.
- `flush` in 1: discard all buffered entries and any beat presented this cycle.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_ctrl` in `control_signals_t`: decoded control bundle.
- `in_instr` in 32: raw instruction word, used for immediate extraction.
- `in_rs1_data` in XLEN: rs1 value.
- `in_rs2_data` in XLEN: rs2 value.
- `in_rd` in 5: destination register index.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_result` out XLEN: ALU result.
- `out_rd` out 5: destination register index.
- `out_reg_write` out `reg_write_t`: writeback enable.

## Operation
- Accept: `in_valid && in_ready && !flush`. Transfer out: `out_valid && out_ready`.
- Immediates, chosen by `imm_type`:
  - IMM_I: sext(instr[31:20]).
  - IMM_S: sext({instr[31:25], instr[11:7]}).
  - IMM_B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - IMM_U: {instr[31:12], 12'b0}.
  - IMM_J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Unused encodings give 0.
- Operand A is always rs1; unused `src_a_sel` encodings are treated as SRC_A_RS1.
- Operand B is the immediate for SRC_B_IMM, otherwise rs2.
- ALU functions:
  - ADD and SUB use modulo 2^32 arithmetic, with no overflow flag.
  - AND, OR and XOR are bitwise.
  - ALU_NOP and unused encodings give result 0.
- `out_reg_write` is WRITE_ENABLE only if `in_ctrl.reg_write` is WRITE_ENABLE and `in_rd != 0`.
- The result is computed at accept time and stored. Stored entries are not recomputed.
- Buffer states:
  - EMPTY: out reg empty.
  - ONE: out reg valid, skid empty.
  - FULL: both valid.
- Buffer transitions (flush takes priority over all of them):
  - EMPTY, on accept: go to ONE.
  - ONE, on accept with transfer out: stay in ONE; the new beat goes into the out reg.
  - ONE, on accept without transfer out: go to FULL; the new beat goes into the skid.
  - ONE, on transfer out without accept: go to EMPTY.
  - FULL, on transfer out: go to ONE; the skid moves into the out reg.
  - FULL, without transfer out: hold.
  - Any state, on flush: go to EMPTY. The presented beat is dropped.
- `in_ready = rst_n && (state != FULL)`. This is a registered-state decode with no combinational path from `out_ready`.
- Order is strictly FIFO. A beat is never lost or duplicated.

## Timing
- Latency: accept on edge N gives `out_valid` high after edge N; the beat is visible in cycle N+1.
- Throughput: one beat per cycle while `out_ready` is held high.
- Output payload stays stable while `out_valid && !out_ready`.
- Reset applies on the edge where `rst_n` is low, from any state, including mid-transfer:
  - State goes to EMPTY.
  - `out_valid` = 0, `out_result` = 0, `out_rd` = 0, `out_reg_write` = WRITE_DISABLE.
  - Skid contents are cleared.
  - `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after.
- Flush in the same cycle as a transfer out: the downstream transfer counts as completed, and the state still goes to EMPTY.

## Structure
- Add to `cpu_pkg`:
  - `localparam XLEN = 32`.
  - `ex_result_t` packed struct holding result, rd and reg_write, used for both buffer entries.
  - `gen_imm(instr, imm_type)` function, to be shared with the branch unit.
- One sub-module: `alu`, purely combinational, taking `alu_op_t`, a and b, and returning the result.
- `ex_stage` contains the immediate and operand muxes, the skid-buffer FSM and the output registers.

## Test plan
- **ADDI:** accept `in_instr=0xFFF08293`, IMM_I, SRC_B_IMM, ALU_ADD, rs1=10, rd=5, reg_write enabled, `out_ready=1`.
  - Next cycle: `out_valid=1`, result=9, rd=5, WRITE_ENABLE.
- **SUB, rs2 operand:** rs1=5, rs2=7 → result `0xFFFFFFFE`.
- **Ordering under backpressure:** `out_ready=0`, then back-to-back beats A, B, C.
  - A lands in the out reg and B in the skid.
  - `in_ready=0` in the cycle C is presented, so C is held.
  - Raise `out_ready`: the outputs appear in order A, B, C with no gaps, losses or duplicates.
- **Flush while FULL, with a beat presented:** next cycle `out_valid=0` and `in_ready=1`; the presented beat never appears.
- **rd=0 and ALU_NOP:**
  - rd=0 with reg_write enabled → WRITE_DISABLE.
  - ALU_NOP with rs1=`0xDEADBEEF` → result 0.
- **Reset mid-operation:** drive `rst_n` low for one cycle while FULL.
  - All outputs take their reset values and `in_ready` is 0 while `rst_n` is low.
  - `in_ready=1` afterwards, and a fresh beat processes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types: decoded control bundle, execute-stage result entry and
// the immediate generator used by both the execute stage and the branch unit.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    typedef enum logic [1:0] {
        SRC_A_RS1 = 2'd0,
        SRC_A_PC  = 2'd1
    } src_a_sel_t;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_sel_t;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5
    } alu_op_t;

    typedef enum logic {
        WRITE_DISABLE = 1'b0,
        WRITE_ENABLE  = 1'b1
    } reg_write_t;

    typedef struct packed {
        alu_op_t    alu_op;
        src_a_sel_t src_a_sel;
        src_b_sel_t src_b_sel;
        imm_type_t  imm_type;
        reg_write_t reg_write;
    } control_signals_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        reg_write_t      reg_write;
    } ex_result_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t imm_type);
        logic [31:0] imm;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU for the execute stage.
module alu
    import cpu_pkg::*;
(
    input  alu_op_t         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: immediate/operand selection, ALU, and a two-entry skid
// buffer (output register + skid register) toward writeback.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  control_signals_t in_ctrl,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output reg_write_t       out_reg_write
);

    buf_state_t      state_q, state_d;
    ex_result_t      out_q, out_d;
    ex_result_t      skid_q, skid_d;
    ex_result_t      new_entry;
    logic [XLEN-1:0] imm, op_a, op_b, alu_res;
    logic            accept, xfer;

    // Opcode bits and src_a_sel carry no information for operand A here.
    logic unused_in;
    assign unused_in = ^{in_instr[6:0], in_ctrl.src_a_sel};

    assign imm  = gen_imm(in_instr, in_ctrl.imm_type);
    assign op_a = in_rs1_data;
    assign op_b = (in_ctrl.src_b_sel == SRC_B_IMM) ? imm : in_rs2_data;

    alu u_alu (
        .op_i     (in_ctrl.alu_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_res)
    );

    always_comb begin
        new_entry.result    = alu_res;
        new_entry.rd        = in_rd;
        new_entry.reg_write = (in_ctrl.reg_write == WRITE_ENABLE && in_rd != 5'd0)
                              ? WRITE_ENABLE : WRITE_DISABLE;
    end

    // Ready decodes registered state only; no path from out_ready.
    assign in_ready      = rst_n && (state_q != BUF_FULL);
    assign out_valid     = (state_q != BUF_EMPTY);
    assign out_result    = out_q.result;
    assign out_rd        = out_q.rd;
    assign out_reg_write = out_q.reg_write;

    assign accept = in_valid && in_ready && !flush;
    assign xfer   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) begin
                    out_d   = new_entry;
                    state_d = BUF_ONE;
                end
                BUF_ONE: begin
                    if (accept && xfer) begin
                        out_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = BUF_FULL;
                    end else if (xfer) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: if (xfer) begin
                    out_d   = skid_q;
                    state_d = BUF_ONE;
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand-written
// backpressure/flush/reset sequences, and a randomized queue-model run.
module tb_ex_stage;
    import cpu_pkg::*;

    logic             clk = 0;
    logic             rst_n, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    control_signals_t in_ctrl;
    logic [31:0]      in_instr, in_rs1_data, in_rs2_data, out_result;
    logic [4:0]       in_rd, out_rd;
    reg_write_t       out_reg_write;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    typedef struct {
        string            name;
        control_signals_t ctrl;
        logic [31:0]      instr, rs1, rs2;
        logic [4:0]       rd;
        logic [31:0]      exp_res;
        logic             exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t model_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic control_signals_t mk(input int op, input int bsel, input int it, input int we);
        control_signals_t c;
        c.alu_op    = alu_op_t'(op[2:0]);
        c.src_a_sel = SRC_A_RS1;
        c.src_b_sel = src_b_sel_t'(bsel[0]);
        c.imm_type  = imm_type_t'(it[2:0]);
        c.reg_write = reg_write_t'(we[0]);
        return c;
    endfunction

    // Reference immediate built from field weights, not bit concatenation.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input int t);
        int v;
        case (t)
            0: v = $signed(ins) >>> 20;
            1: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            2: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            3: v = int'(ins & 32'hFFFF_F000);
            4: v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic exp_t ref_model(input control_signals_t c, input logic [31:0] ins,
                                       input logic [31:0] a, input logic [31:0] r2, input logic [4:0] rd);
        exp_t e;
        logic [31:0] b;
        b = (c.src_b_sel == SRC_B_IMM) ? ref_imm(ins, int'(c.imm_type)) : r2;
        case (int'(c.alu_op))
            1: e.res = a + b;
            2: e.res = a - b;
            3: e.res = a & b;
            4: e.res = a | b;
            5: e.res = a ^ b;
            default: e.res = 0;
        endcase
        e.rd = rd;
        e.we = (c.reg_write == WRITE_ENABLE) && (rd != 0);
        return e;
    endfunction

    task automatic drive(input control_signals_t c, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1; in_ctrl = c; in_instr = ins; in_rs1_data = a; in_rs2_data = b; in_rd = rd;
    endtask

    task automatic chk_out(input string name, input logic [31:0] res, input logic [4:0] rd, input logic we);
        chk({name, ".valid"}, 64'(out_valid), 64'd1);
        chk({name, ".result"}, 64'(out_result), 64'(res));
        chk({name, ".rd"}, 64'(out_rd), 64'(rd));
        chk({name, ".we"}, 64'(out_reg_write), 64'(we));
    endtask

    vec_t vecs[12];

    initial begin
        // name, ctrl(op,bsel,imm,we), instr, rs1, rs2, rd, expected result, expected we
        vecs[0]  = '{"addi",    mk(1,1,0,1), 32'hFFF08293, 32'd10,        32'd0,         5'd5,  32'd9,         1'b1};
        vecs[1]  = '{"sub",     mk(2,0,0,1), 32'h0,        32'd5,         32'd7,         5'd6,  32'hFFFFFFFE,  1'b1};
        vecs[2]  = '{"rd0",     mk(1,0,0,1), 32'h0,        32'd1,         32'd2,         5'd0,  32'd3,         1'b0};
        vecs[3]  = '{"nop",     mk(0,0,0,1), 32'h0,        32'hDEADBEEF,  32'h1,         5'd7,  32'd0,         1'b1};
        vecs[4]  = '{"and",     mk(3,0,0,0), 32'h0,        32'hF0F0F0F0,  32'hFF00FF00,  5'd8,  32'hF000F000,  1'b0};
        vecs[5]  = '{"or",      mk(4,0,0,1), 32'h0,        32'hF0F0F0F0,  32'hFF00FF00,  5'd9,  32'hFFF0FFF0,  1'b1};
        vecs[6]  = '{"xor",     mk(5,0,0,1), 32'h0,        32'hF0F0F0F0,  32'hFF00FF00,  5'd10, 32'h0FF00FF0,  1'b1};
        vecs[7]  = '{"imm_u",   mk(1,1,3,1), 32'h12345037, 32'd0,         32'd0,         5'd11, 32'h12345000,  1'b1};
        vecs[8]  = '{"imm_s",   mk(1,1,1,0), 32'hFE000E23, 32'd100,       32'd0,         5'd12, 32'h60,        1'b0};
        vecs[9]  = '{"imm_b",   mk(1,1,2,1), 32'h00000463, 32'd0,         32'd0,         5'd13, 32'd8,         1'b1};
        vecs[10] = '{"imm_j",   mk(1,1,4,1), 32'hFFFFF06F, 32'd0,         32'd0,         5'd14, 32'hFFFFFFFE,  1'b1};
        vecs[11] = '{"badop",   mk(7,1,7,1), 32'hFFFFFFFF, 32'h1234,      32'd6,         5'd15, 32'd0,         1'b1};

        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_ctrl = '0; in_instr = 0; in_rs1_data = 0; in_rs2_data = 0; in_rd = 0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'd0);
        chk("reset.valid", 64'(out_valid), 64'd0);
        rst_n = 1;
        #1 chk("post_reset.in_ready", 64'(in_ready), 64'd1);

        // Single-beat table with out_ready high.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            @(negedge clk);
            in_valid = 0;
            chk_out(vecs[i].name, vecs[i].exp_res, vecs[i].rd, vecs[i].exp_we);
        end
        @(negedge clk);
        chk("drain.valid", 64'(out_valid), 64'd0);

        // Ordering under backpressure: A -> out reg, B -> skid, C held.
        out_ready = 0;
        drive(mk(1,0,0,1), 0, 32'hA, 0, 5'd1);
        @(negedge clk); drive(mk(1,0,0,1), 0, 32'hB, 0, 5'd2);
        @(negedge clk); drive(mk(1,0,0,1), 0, 32'hC, 0, 5'd3);
        #1 chk("bp.full_in_ready", 64'(in_ready), 64'd0);
        chk_out("bp.holdA", 32'hA, 5'd1, 1'b1);
        @(negedge clk);
        chk_out("bp.stableA", 32'hA, 5'd1, 1'b1);
        out_ready = 1;
        @(negedge clk);
        chk_out("bp.B", 32'hB, 5'd2, 1'b1);
        chk("bp.ready_after", 64'(in_ready), 64'd1);
        @(negedge clk); in_valid = 0;
        chk_out("bp.C", 32'hC, 5'd3, 1'b1);
        @(negedge clk);
        chk("bp.empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a beat presented.
        out_ready = 0;
        drive(mk(1,0,0,1), 0, 32'h11, 0, 5'd1);
        @(negedge clk); drive(mk(1,0,0,1), 0, 32'h22, 0, 5'd2);
        @(negedge clk); drive(mk(1,0,0,1), 0, 32'h33, 0, 5'd3); flush = 1;
        @(negedge clk); flush = 0; in_valid = 0;
        chk("flush.valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1;
        repeat (2) begin
            @(negedge clk);
            chk("flush.no_ghost", 64'(out_valid), 64'd0);
        end

        // Reset while FULL.
        out_ready = 0;
        drive(mk(1,0,0,1), 0, 32'h44, 0, 5'd4);
        @(negedge clk); drive(mk(1,0,0,1), 0, 32'h55, 0, 5'd5);
        @(negedge clk); in_valid = 0; rst_n = 0;
        #1 chk("rst.in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(out_result), 64'd0);
        chk("rst.rd", 64'(out_rd), 64'd0);
        chk("rst.we", 64'(out_reg_write), 64'd0);
        rst_n = 1; out_ready = 1;
        #1 chk("rst.in_ready_after", 64'(in_ready), 64'd1);
        drive(vecs[0].ctrl, vecs[0].instr, vecs[0].rs1, vecs[0].rs2, vecs[0].rd);
        @(negedge clk); in_valid = 0;
        chk_out("rst.fresh", 32'd9, 5'd5, 1'b1);
        @(negedge clk);

        // Randomized traffic against a queue model of capacity two.
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            control_signals_t c;
            exp_t e;
            c = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
            drive(c, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 15) == 0) in_rd = 0;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            #1;
            chk("rnd.out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            chk("rnd.in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            if (out_valid && out_ready && model_q.size() > 0) begin
                e = model_q.pop_front();
                chk("rnd.beat", {out_result, 3'b0, out_rd, 7'b0, 1'(out_reg_write)},
                                {e.res, 3'b0, e.rd, 7'b0, e.we});
            end
            if (flush)
                model_q.delete();
            else if (in_valid && in_ready)
                model_q.push_back(ref_model(in_ctrl, in_instr, in_rs1_data, in_rs2_data, in_rd));
            @(negedge clk);
        end
        in_valid = 0; flush = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
